// File: rtl/decode_queue_pkg.sv
// Shared decode types for the multi-issue decode queue.
// Contents: RV32I major-opcode enum, decoded instruction struct (inst_t), RVFI template
// struct (rvfi_data_t), queue entry struct (decq_entry_t) and default sizing.
// Optional feature macro: RVFI_DECODE_EN adds the rvfi template to every queue entry.
package decode_queue_pkg;

  parameter int unsigned DECQ_WIDTH = 2;
  parameter int unsigned DECQ_DEPTH = 8;

  typedef enum logic [6:0] {
    OpLoad    = 7'h03,
    OpMiscMem = 7'h0f,
    OpOpImm   = 7'h13,
    OpAuipc   = 7'h17,
    OpStore   = 7'h23,
    OpOp      = 7'h33,
    OpLui     = 7'h37,
    OpBranch  = 7'h63,
    OpJalr    = 7'h67,
    OpJal     = 7'h6f,
    OpSystem  = 7'h73
  } rv32i_opcode_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
  } inst_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] r1_rdata;
    logic [31:0] r2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_data_t;

  typedef struct packed {
    inst_t       inst;
    logic [31:0] pc;
`ifdef RVFI_DECODE_EN
    rvfi_data_t  rvfi;
`endif
  } decq_entry_t;

  // Sign-extend a 12-bit immediate to 32 bits.
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch/dispatch handshake bundle for decode_queue.
// Fetch side:    in_valid (prefix mask), in_inst (WIDTH raw words), in_pc (lane 0 PC), in_ready.
// Dispatch side: out_valid, out_inst, out_pc (oldest first), deq_cnt (entries popped).
// Modports: slave = the queue, master = the fetch/dispatch environment.
// Optional feature macro: RVFI_DECODE_EN adds out_rvfi.
interface decode_queue_if import decode_queue_pkg::*; #(
  parameter int unsigned WIDTH = DECQ_WIDTH
);
  localparam int unsigned DcW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]            in_valid;
  logic [WIDTH*32-1:0]         in_inst;
  logic [31:0]                 in_pc;
  logic                        in_ready;
  logic [WIDTH-1:0]            out_valid;
  inst_t [WIDTH-1:0]           out_inst;
  logic [WIDTH-1:0][31:0]      out_pc;
  logic [DcW-1:0]              deq_cnt;
`ifdef RVFI_DECODE_EN
  rvfi_data_t [WIDTH-1:0]      out_rvfi;
`endif

  modport slave (
`ifdef RVFI_DECODE_EN
    output out_rvfi,
`endif
    input  in_valid,
    input  in_inst,
    input  in_pc,
    input  deq_cnt,
    output in_ready,
    output out_valid,
    output out_inst,
    output out_pc
  );

  modport master (
`ifdef RVFI_DECODE_EN
    input  out_rvfi,
`endif
    output in_valid,
    output in_inst,
    output in_pc,
    output deq_cnt,
    input  in_ready,
    input  out_valid,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/rv32i_field_decode.sv
// Pure combinational single-instruction RV32I field decoder.
// Ports: inst_word (raw 32-bit instruction) -> inst (decoded fields, sign-extended immediates,
// register fields zeroed where the format has no such operand).
// Optional feature macro: RVFI_DECODE_EN adds pc input and rvfi template output.
module rv32i_field_decode import decode_queue_pkg::*; (
  input  logic [31:0] inst_word,
`ifdef RVFI_DECODE_EN
  input  logic [31:0] pc,
  output rvfi_data_t  rvfi,
`endif
  output inst_t       inst
);

  logic zero_rs1, zero_rs2, zero_rd;

  // Formats without an rs1/rs2/rd operand must not report stray encoding bits as registers.
  always_comb begin
    zero_rs1 = 1'b0;
    zero_rs2 = 1'b0;
    zero_rd  = 1'b0;
    case (inst_word[6:0])
      OpLui, OpAuipc, OpJal: begin
        zero_rs1 = 1'b1;
        zero_rs2 = 1'b1;
      end
      OpLoad, OpOpImm, OpJalr: zero_rs2 = 1'b1;
      OpBranch, OpStore:       zero_rd  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    inst        = '0;
    inst.opcode = inst_word[6:0];
    inst.funct3 = inst_word[14:12];
    inst.funct7 = inst_word[31:25];
    inst.rs1    = zero_rs1 ? 5'd0 : inst_word[19:15];
    inst.rs2    = zero_rs2 ? 5'd0 : inst_word[24:20];
    inst.rd     = zero_rd  ? 5'd0 : inst_word[11:7];
    inst.i_imm  = sext12(inst_word[31:20]);
    inst.s_imm  = sext12({inst_word[31:25], inst_word[11:7]});
    inst.b_imm  = {{19{inst_word[31]}}, inst_word[31], inst_word[7], inst_word[30:25],
                   inst_word[11:8], 1'b0};
    inst.u_imm  = {inst_word[31:12], 12'h000};
    inst.j_imm  = {{11{inst_word[31]}}, inst_word[31], inst_word[19:12], inst_word[20],
                   inst_word[30:21], 1'b0};
  end

`ifdef RVFI_DECODE_EN
  // Data fields are left zero; later pipeline stages fill them in.
  always_comb begin
    rvfi          = '0;
    rvfi.inst     = inst_word;
    rvfi.rs1_addr = inst.rs1;
    rvfi.rs2_addr = inst.rs2;
    rvfi.rd_addr  = inst.rd;
    rvfi.pc_rdata = pc;
    rvfi.pc_wdata = pc + 32'd4;
  end
`endif

endmodule

// File: rtl/decode_queue.sv
// Multi-issue decode queue: decodes up to WIDTH fetched instructions per cycle and buffers
// them in an in-order circular queue of DEPTH entries; dispatch pops 0..WIDTH per cycle.
// Ports: clk, rst (synchronous, active high), flush (empties queue, drops same-cycle traffic),
// bus (decode_queue_if.slave: fetch and dispatch handshakes), occupancy (entry count).
// Optional feature macro: RVFI_DECODE_EN stores an rvfi template per entry (bus.out_rvfi).
module decode_queue import decode_queue_pkg::*; #(
  parameter int unsigned WIDTH = DECQ_WIDTH,
  parameter int unsigned DEPTH = DECQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  decode_queue_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  decq_entry_t lane_entry [WIDTH];
  decq_entry_t mem_q      [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  cnt_t n_lead, n_enq, n_deq, deq_ext;
  logic enq_fire;
  logic seen_gap;

  // Per-lane decode ahead of the queue write.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    logic [31:0] lane_pc;
    inst_t       lane_inst;
    decq_entry_t lane_e;
`ifdef RVFI_DECODE_EN
    rvfi_data_t  lane_rvfi;
`endif

    assign lane_pc = bus.in_pc + 32'(4 * g);

    rv32i_field_decode u_decode (
      .inst_word (bus.in_inst[32*g +: 32]),
`ifdef RVFI_DECODE_EN
      .pc        (lane_pc),
      .rvfi      (lane_rvfi),
`endif
      .inst      (lane_inst)
    );

    always_comb begin
      lane_e      = '0;
      lane_e.inst = lane_inst;
      lane_e.pc   = lane_pc;
`ifdef RVFI_DECODE_EN
      lane_e.rvfi = lane_rvfi;
`endif
    end

    assign lane_entry[g] = lane_e;
  end

  // Only the leading contiguous run of valid lanes is accepted; a gap ends the group.
  always_comb begin
    n_lead   = '0;
    seen_gap = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_valid[i] && !seen_gap) begin
        n_lead = n_lead + cnt_t'(1);
      end else begin
        seen_gap = 1'b1;
      end
    end
  end

  // No deq_cnt bypass: readiness depends on registered occupancy only.
  assign bus.in_ready = (count_q <= cnt_t'(DEPTH - WIDTH));

  assign enq_fire = bus.in_ready && (n_lead != '0) && !flush;
  assign n_enq    = enq_fire ? n_lead : '0;
  assign deq_ext  = cnt_t'(bus.deq_cnt);

  // Over-request is clamped to what is actually held.
  always_comb begin
    n_deq = '0;
    if (!flush) begin
      n_deq = (deq_ext > count_q) ? count_q : deq_ext;
    end
  end

  always_comb begin
    head_d  = head_q + ptr_t'(n_deq);
    tail_d  = tail_q + ptr_t'(n_enq);
    count_d = count_q + n_enq - n_deq;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage has no reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_t'(i) < n_lead) begin
          mem_q[tail_q + ptr_t'(i)] <= lane_entry[i];
        end
      end
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_inst  = '0;
    bus.out_pc    = '0;
`ifdef RVFI_DECODE_EN
    bus.out_rvfi  = '0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      bus.out_valid[i] = (count_q > cnt_t'(i));
      bus.out_inst[i]  = mem_q[head_q + ptr_t'(i)].inst;
      bus.out_pc[i]    = mem_q[head_q + ptr_t'(i)].pc;
`ifdef RVFI_DECODE_EN
      bus.out_rvfi[i]  = mem_q[head_q + ptr_t'(i)].rvfi;
`endif
    end
  end

  assign occupancy = count_q;

  // A prefix mask plus one has no bits in common with the mask itself.
  logic [WIDTH-1:0] valid_inc;
  assign valid_inc = bus.in_valid + WIDTH'(1);

  a_in_valid_prefix: assert property (@(posedge clk) disable iff (rst)
    ((bus.in_valid & valid_inc) == '0));

  a_deq_within_count: assert property (@(posedge clk) disable iff (rst)
    (flush || (deq_ext <= count_q)));

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned W = 2;
  localparam int unsigned D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] occupancy;

  int tests_run    = 0;
  int tests_failed = 0;

  decode_queue_if #(.WIDTH(W)) bus ();

  decode_queue #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i1, input logic [31:0] i0,
                       input logic [31:0] pc, input logic [1:0] dc);
    bus.in_valid = v;
    bus.in_inst  = {i1, i0};
    bus.in_pc    = pc;
    bus.deq_cnt  = dc;
  endtask

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0] grp_pc;

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_occupancy", 32'(occupancy), 32'h0);

    // addi x1,x0,5 + sw x1,0(x2)
    drive(2'b11, 32'h0011_2023, 32'h0050_0093, 32'h1000, 2'd0);
    step();
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("enq_out_valid", 32'(bus.out_valid), 32'h3);
    check("enq_pc0", bus.out_pc[0], 32'h1000);
    check("enq_pc1", bus.out_pc[1], 32'h1004);
    check("addi_rs2", 32'(bus.out_inst[0].rs2), 32'h0);
    check("addi_i_imm", bus.out_inst[0].i_imm, 32'h5);
    check("addi_rd", 32'(bus.out_inst[0].rd), 32'h1);
    check("sw_rd", 32'(bus.out_inst[1].rd), 32'h0);
    check("sw_rs1", 32'(bus.out_inst[1].rs1), 32'h2);
    check("sw_rs2", 32'(bus.out_inst[1].rs2), 32'h1);
    check("enq_occupancy", 32'(occupancy), 32'h2);
`ifdef RVFI_DECODE_EN
    check("rvfi_pc_wdata", bus.out_rvfi[0].pc_wdata, 32'h1004);
    check("rvfi_rs2_addr", 32'(bus.out_rvfi[0].rs2_addr), 32'h0);
    check("rvfi_inst", bus.out_rvfi[1].inst, 32'h0011_2023);
`endif

    drive(2'b00, Nop, Nop, 32'h0, 2'd2);
    step();
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("drain_occupancy", 32'(occupancy), 32'h0);
    check("drain_out_valid", 32'(bus.out_valid), 32'h0);

    // Fill to DEPTH starting from head=tail=2 so the pointers wrap.
    for (int g = 0; g < 4; g++) begin
      drive(2'b11, Nop, Nop, 32'h2000 + 32'(8 * g), 2'd0);
      step();
    end
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    check("full_occupancy", 32'(occupancy), 32'h8);
    check("full_out_valid", 32'(bus.out_valid), 32'h3);

    // Cycle 0 is rejected (full); fetch holds group 0x2020 and it lands on cycle 1.
    grp_pc = 32'h2020;
    for (int c = 0; c < 6; c++) begin
      check("wrap_pc0", bus.out_pc[0], 32'h2000 + 32'(8 * c));
      check("wrap_pc1", bus.out_pc[1], 32'h2004 + 32'(8 * c));
      check("wrap_in_ready", 32'(bus.in_ready), (c == 0) ? 32'h0 : 32'h1);
      drive(2'b11, Nop, Nop, grp_pc, 2'd2);
      step();
      if (c > 0) grp_pc = grp_pc + 32'h8;
    end
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("wrap_occupancy", 32'(occupancy), 32'h6);
    check("wrap_head_pc", bus.out_pc[0], 32'h2030);

    drive(2'b00, Nop, Nop, 32'h0, 2'd1);
    step();
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("pre_flush_occ", 32'(occupancy), 32'h5);
    check("pre_flush_pc0", bus.out_pc[0], 32'h2034);

    // Flush with a same-cycle enqueue: the 0x3000 group must vanish.
    flush = 1'b1;
    drive(2'b11, Nop, Nop, 32'h3000, 2'd0);
    step();
    flush = 1'b0;
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("flush_occupancy", 32'(occupancy), 32'h0);
    check("flush_out_valid", 32'(bus.out_valid), 32'h0);
    check("flush_in_ready", 32'(bus.in_ready), 32'h1);

    drive(2'b11, Nop, Nop, 32'h4000, 2'd0);
    step();
    check("post_flush_pc0", bus.out_pc[0], 32'h4000);
    check("post_flush_occ", 32'(occupancy), 32'h2);

    drive(2'b01, Nop, Nop, 32'h5000, 2'd0);
    step();
    check("single_lane_occ", 32'(occupancy), 32'h3);

    // count=3: enqueue one, pop two in the same cycle.
    drive(2'b01, Nop, Nop, 32'h6000, 2'd2);
    step();
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("simul_occupancy", 32'(occupancy), 32'h2);
    check("simul_pc0", bus.out_pc[0], 32'h5000);
    check("simul_pc1", bus.out_pc[1], 32'h6000);
    check("simul_out_valid", 32'(bus.out_valid), 32'h3);

    drive(2'b00, Nop, Nop, 32'h0, 2'd2);
    step();

    // jal x1,-4 in lane 0, lui x5,0xABCDE in lane 1
    drive(2'b11, 32'hABCD_E2B7, 32'hFFDF_F0EF, 32'h7000, 2'd0);
    step();
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("jal_j_imm", bus.out_inst[0].j_imm, 32'hFFFF_FFFC);
    check("jal_rs1", 32'(bus.out_inst[0].rs1), 32'h0);
    check("jal_rs2", 32'(bus.out_inst[0].rs2), 32'h0);
    check("jal_rd", 32'(bus.out_inst[0].rd), 32'h1);
    check("lui_u_imm", bus.out_inst[1].u_imm, 32'hABCD_E000);
    check("lui_rs1", 32'(bus.out_inst[1].rs1), 32'h0);
    check("lui_rd", 32'(bus.out_inst[1].rd), 32'h5);
    check("lui_pc", bus.out_pc[1], 32'h7004);

    drive(2'b00, Nop, Nop, 32'h0, 2'd2);
    step();

    // sw x1,8(x2) in lane 0, beq x1,x2,-8 in lane 1
    drive(2'b11, 32'hFE20_8CE3, 32'h0011_2423, 32'h8000, 2'd0);
    step();
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("sw8_s_imm", bus.out_inst[0].s_imm, 32'h8);
    check("sw8_rd", 32'(bus.out_inst[0].rd), 32'h0);
    check("beq_b_imm", bus.out_inst[1].b_imm, 32'hFFFF_FFF8);
    check("beq_rd", 32'(bus.out_inst[1].rd), 32'h0);
    check("beq_rs1", 32'(bus.out_inst[1].rs1), 32'h1);
    check("beq_rs2", 32'(bus.out_inst[1].rs2), 32'h2);
    check("beq_opcode", 32'(bus.out_inst[1].opcode), 32'h63);

    drive(2'b00, Nop, Nop, 32'h0, 2'd2);
    step();
    drive(2'b00, Nop, Nop, 32'h0, 2'd0);
    check("end_occupancy", 32'(occupancy), 32'h0);
    check("end_out_valid", 32'(bus.out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
